// File: rtl/ex_pkg.sv
// Shared encodings for the EX stage: ALU opcodes, result classes, HI/LO and stall constants.
package ex_pkg;
  localparam int REG_W  = 32;
  localparam int ADDR_W = 5;
  localparam int OP_W   = 8;
  localparam int SEL_W  = 3;

  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;
  localparam logic STOP          = 1'b1;
  localparam logic NO_STOP       = 1'b0;

  localparam logic [SEL_W-1:0] RES_NOP         = 3'b000;
  localparam logic [SEL_W-1:0] RES_LOGIC       = 3'b001;
  localparam logic [SEL_W-1:0] RES_SHIFT       = 3'b010;
  localparam logic [SEL_W-1:0] RES_MOVE        = 3'b011;
  localparam logic [SEL_W-1:0] RES_ARITH       = 3'b100;
  localparam logic [SEL_W-1:0] RES_MUL         = 3'b101;
  localparam logic [SEL_W-1:0] RES_JUMP_BRANCH = 3'b110;

  localparam logic [OP_W-1:0] EXE_NOP_OP   = 8'b00000000;
  localparam logic [OP_W-1:0] EXE_AND_OP   = 8'b00100100;
  localparam logic [OP_W-1:0] EXE_OR_OP    = 8'b00100101;
  localparam logic [OP_W-1:0] EXE_XOR_OP   = 8'b00100110;
  localparam logic [OP_W-1:0] EXE_NOR_OP   = 8'b00100111;
  localparam logic [OP_W-1:0] EXE_SLL_OP   = 8'b01111100;
  localparam logic [OP_W-1:0] EXE_SRL_OP   = 8'b00000010;
  localparam logic [OP_W-1:0] EXE_SRA_OP   = 8'b00000011;
  localparam logic [OP_W-1:0] EXE_MOVZ_OP  = 8'b00001010;
  localparam logic [OP_W-1:0] EXE_MOVN_OP  = 8'b00001011;
  localparam logic [OP_W-1:0] EXE_MFHI_OP  = 8'b00010000;
  localparam logic [OP_W-1:0] EXE_MTHI_OP  = 8'b00010001;
  localparam logic [OP_W-1:0] EXE_MFLO_OP  = 8'b00010010;
  localparam logic [OP_W-1:0] EXE_MTLO_OP  = 8'b00010011;
  localparam logic [OP_W-1:0] EXE_SLT_OP   = 8'b00101010;
  localparam logic [OP_W-1:0] EXE_SLTU_OP  = 8'b00101011;
  localparam logic [OP_W-1:0] EXE_ADD_OP   = 8'b00100000;
  localparam logic [OP_W-1:0] EXE_ADDU_OP  = 8'b00100001;
  localparam logic [OP_W-1:0] EXE_SUB_OP   = 8'b00100010;
  localparam logic [OP_W-1:0] EXE_SUBU_OP  = 8'b00100011;
  localparam logic [OP_W-1:0] EXE_ADDI_OP  = 8'b01010101;
  localparam logic [OP_W-1:0] EXE_ADDIU_OP = 8'b01010110;
  localparam logic [OP_W-1:0] EXE_MULT_OP  = 8'b00011000;
  localparam logic [OP_W-1:0] EXE_MULTU_OP = 8'b00011001;
  localparam logic [OP_W-1:0] EXE_MUL_OP   = 8'b10101001;
  localparam logic [OP_W-1:0] EXE_MADD_OP  = 8'b10100110;
  localparam logic [OP_W-1:0] EXE_MADDU_OP = 8'b10101000;
  localparam logic [OP_W-1:0] EXE_MSUB_OP  = 8'b10101010;
  localparam logic [OP_W-1:0] EXE_MSUBU_OP = 8'b10101011;

  typedef enum logic {IDLE, ACC} madd_state_e;

  function automatic logic is_madd(input logic [OP_W-1:0] op);
    return op == EXE_MADD_OP || op == EXE_MADDU_OP || op == EXE_MSUB_OP || op == EXE_MSUBU_OP;
  endfunction
endpackage

// File: rtl/ex_mul.sv
// 32x32 -> 64 multiplier; signed_op selects two's-complement or unsigned operands.
module ex_mul
  import ex_pkg::*;
(
  input  logic [REG_W-1:0]   a,
  input  logic [REG_W-1:0]   b,
  input  logic               signed_op,
  output logic [2*REG_W-1:0] prod
);
  logic signed [REG_W:0] a_x, b_x;

  // One extra bit carries the sign (or a zero for unsigned), so one signed multiply covers both.
  assign a_x  = {signed_op & a[REG_W-1], a};
  assign b_x  = {signed_op & b[REG_W-1], b};
  assign prod = 64'(a_x) * 64'(b_x);
endmodule

// File: rtl/ex.sv
// MIPS EX stage: combinational ALU/HI-LO result plus a two-cycle multiply-accumulate FSM.
module ex
  import ex_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [OP_W-1:0]   aluop_i,
  input  logic [SEL_W-1:0]  alusel_i,
  input  logic [REG_W-1:0]  reg1_i,
  input  logic [REG_W-1:0]  reg2_i,
  input  logic [ADDR_W-1:0] wd_i,
  input  logic              wreg_i,
  input  logic [REG_W-1:0]  link_address_i,
  input  logic [REG_W-1:0]  hi_i,
  input  logic [REG_W-1:0]  lo_i,
  input  logic              hold_i,
  output logic [ADDR_W-1:0] wd_o,
  output logic              wreg_o,
  output logic [REG_W-1:0]  wdata_o,
  output logic              whilo_o,
  output logic [REG_W-1:0]  hi_o,
  output logic [REG_W-1:0]  lo_o,
  output logic              stallreq_o
);
  madd_state_e state, state_nxt;
  logic [2*REG_W-1:0] temp, temp_nxt, prod, madd_sum;
  logic madd_stall, madd_we, mul_signed, ov;
  logic [REG_W-1:0] logic_res, shift_res, arith_res, move_res, sum, diff, result;
  logic [REG_W-1:0] hi_res, lo_res;
  logic whilo_res;

  assign mul_signed = !(aluop_i == EXE_MULTU_OP || aluop_i == EXE_MADDU_OP ||
                        aluop_i == EXE_MSUBU_OP);

  ex_mul u_mul (.a(reg1_i), .b(reg2_i), .signed_op(mul_signed), .prod(prod));

  assign sum      = reg1_i + reg2_i;
  assign diff     = reg1_i - reg2_i;
  assign madd_sum = {hi_i, lo_i} + temp;

  always_comb begin
    logic_res = '0;
    case (aluop_i)
      EXE_AND_OP: logic_res = reg1_i & reg2_i;
      EXE_OR_OP:  logic_res = reg1_i | reg2_i;
      EXE_XOR_OP: logic_res = reg1_i ^ reg2_i;
      EXE_NOR_OP: logic_res = ~(reg1_i | reg2_i);
      default:    logic_res = '0;
    endcase
  end

  always_comb begin
    shift_res = '0;
    case (aluop_i)
      EXE_SLL_OP: shift_res = reg2_i << reg1_i[4:0];
      EXE_SRL_OP: shift_res = reg2_i >> reg1_i[4:0];
      EXE_SRA_OP: shift_res = $signed(reg2_i) >>> reg1_i[4:0];
      default:    shift_res = '0;
    endcase
  end

  // Overflow: operands agree (add) or differ (sub) in sign, and the result sign flips from reg1.
  always_comb begin
    arith_res = '0;
    ov        = 1'b0;
    case (aluop_i)
      EXE_ADD_OP, EXE_ADDI_OP: begin
        arith_res = sum;
        ov        = (reg1_i[31] == reg2_i[31]) && (sum[31] != reg1_i[31]);
      end
      EXE_ADDU_OP, EXE_ADDIU_OP: arith_res = sum;
      EXE_SUB_OP: begin
        arith_res = diff;
        ov        = (reg1_i[31] != reg2_i[31]) && (diff[31] != reg1_i[31]);
      end
      EXE_SUBU_OP: arith_res = diff;
      EXE_SLT_OP:  arith_res = {31'b0, $signed(reg1_i) < $signed(reg2_i)};
      EXE_SLTU_OP: arith_res = {31'b0, reg1_i < reg2_i};
      default:     arith_res = '0;
    endcase
  end

  always_comb begin
    move_res = '0;
    case (aluop_i)
      EXE_MFHI_OP:              move_res = hi_i;
      EXE_MFLO_OP:              move_res = lo_i;
      EXE_MOVZ_OP, EXE_MOVN_OP: move_res = reg1_i;
      default:                  move_res = '0;
    endcase
  end

  always_comb begin
    result = '0;
    case (alusel_i)
      RES_LOGIC:       result = logic_res;
      RES_SHIFT:       result = shift_res;
      RES_MOVE:        result = move_res;
      RES_ARITH:       result = arith_res;
      RES_MUL:         result = prod[REG_W-1:0];
      RES_JUMP_BRANCH: result = link_address_i;
      default:         result = '0;
    endcase
  end

  always_comb begin
    state_nxt  = state;
    temp_nxt   = temp;
    madd_stall = NO_STOP;
    madd_we    = 1'b0;
    case (state)
      IDLE: if (is_madd(aluop_i)) begin
        temp_nxt   = (aluop_i == EXE_MSUB_OP || aluop_i == EXE_MSUBU_OP) ? -prod : prod;
        state_nxt  = ACC;
        madd_stall = STOP;
      end
      ACC: begin
        // A non-MADD op here means the pipeline was flushed; drop the accumulate.
        madd_we   = is_madd(aluop_i);
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      temp  <= '0;
    end else if (!hold_i) begin
      state <= state_nxt;
      temp  <= temp_nxt;
    end
  end

  always_comb begin
    whilo_res = WRITE_DISABLE;
    hi_res    = '0;
    lo_res    = '0;
    if (madd_we) begin
      whilo_res        = WRITE_ENABLE;
      {hi_res, lo_res} = madd_sum;
    end else begin
      case (aluop_i)
        EXE_MULT_OP, EXE_MULTU_OP: begin
          whilo_res        = WRITE_ENABLE;
          {hi_res, lo_res} = prod;
        end
        EXE_MTHI_OP: begin
          whilo_res = WRITE_ENABLE;
          hi_res    = reg1_i;
          lo_res    = lo_i;
        end
        EXE_MTLO_OP: begin
          whilo_res = WRITE_ENABLE;
          hi_res    = hi_i;
          lo_res    = reg1_i;
        end
        default: whilo_res = WRITE_DISABLE;
      endcase
    end
  end

  assign wd_o       = rst ? '0 : wd_i;
  assign wreg_o     = rst ? WRITE_DISABLE : (wreg_i & ~ov);
  assign wdata_o    = rst ? '0 : result;
  assign whilo_o    = rst ? WRITE_DISABLE : whilo_res;
  assign hi_o       = rst ? '0 : hi_res;
  assign lo_o       = rst ? '0 : lo_res;
  assign stallreq_o = rst ? NO_STOP : madd_stall;
endmodule

// File: doc/ex.md
EX -- requirements
Module: ex

Interface
REQ-001 Parameters: none; all widths and opcode encodings come from the shared defines file.
REQ-002 clk  input  1  clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 aluop_i  input  8  operation subtype from the ID/EX register.
REQ-005 alusel_i  input  3  result class: NOP, LOGIC, SHIFT, MOVE, ARITH, MUL, JUMP_BRANCH.
REQ-006 reg1_i  input  32  source operand 1 (shift amount in bits [4:0] for shifts).
REQ-007 reg2_i  input  32  source operand 2.
REQ-008 wd_i  input  5  destination register address.
REQ-009 wreg_i  input  1  destination write enable.
REQ-010 link_address_i  input  32  return address for link-type branch/jump.
REQ-011 hi_i / lo_i  input  32 each  current HI/LO, already forwarded from MEM/WB.
REQ-012 hold_i  input  1  a later stage is stalled; EX results will not be captured this cycle.
REQ-013 wd_o  output  5  destination address; wreg_o  output  1  write enable; wdata_o  output  32  result.
REQ-014 whilo_o  output  1  HI/LO write enable; hi_o / lo_o  output  32 each  new HI/LO values.
REQ-015 stallreq_o  output  1  EX requests a pipeline stall (multi-cycle op in progress).

Function
REQ-016 Result datapath SHALL be combinational from inputs plus internal state; wd_o follows wd_i directly.
REQ-017 LOGIC: AND/OR/XOR/NOR of reg1_i and reg2_i; SHIFT: SLL/SRL/SRA of reg2_i by reg1_i[4:0]; SRA sign-fills.
REQ-018 ARITH: ADD/ADDU/ADDI/ADDIU/SUB/SUBU sum/difference mod 2^32; SLT signed compare, SLTU unsigned compare, result 0 or 1.
REQ-019 On signed overflow of ADD/ADDI/SUB, wreg_o SHALL be 0; wreg_o = wreg_i for all other ops.
REQ-020 MOVE: MFHI -> hi_i, MFLO -> lo_i, MOVZ/MOVN -> reg1_i (write gating already resolved by ID).
REQ-021 MUL: wdata_o = low 32 bits of the signed 64-bit product; JUMP_BRANCH: wdata_o = link_address_i; NOP/unknown: wdata_o = 0.
REQ-022 MULT/MULTU: whilo_o = 1, {hi_o,lo_o} = signed/unsigned 64-bit product; MTHI: hi_o = reg1_i, lo_o = lo_i; MTLO: the converse; otherwise whilo_o = 0 and hi_o/lo_o = 0.
REQ-023 MADD/MADDU/MSUB/MSUBU SHALL use a two-state FSM, IDLE and ACC, with a 64-bit temp register.
REQ-024 IDLE with a MADD-class op present: temp <= product (two's-complement negated for MSUB/MSUBU); state -> ACC; stallreq_o = 1; whilo_o = 0.
REQ-025 ACC: {hi_o,lo_o} = {hi_i,lo_i} + temp (mod 2^64); whilo_o = 1; stallreq_o = 0; state -> IDLE.
REQ-026 hold_i = 1 freezes state and temp; outputs keep their current combinational values.
REQ-027 ACC with a non-MADD-class op present (flushed pipeline) SHALL return to IDLE without asserting whilo_o.
REQ-028 Latency: single-cycle ops complete in 1 cycle; MADD-class ops in exactly 2 cycles when hold_i = 0.

Reset
REQ-029 rst = 1: state = IDLE, temp = 0, and all outputs 0 (wreg_o and whilo_o disabled, stallreq_o = 0), regardless of FSM state.

Structure
REQ-030 Opcode, alusel codes, HI/LO and stall constants SHALL live in the shared defines file; no local encodings.
REQ-031 A sub-module is optional: ex_mul (signed/unsigned 32x32 -> 64 multiplier), shared by MUL, MULT and the MADD class.

Verification
REQ-032 ADD, reg1 = 0x7FFFFFFF, reg2 = 1 -> wdata_o = 0x80000000, wreg_o = 0; ADDU with the same operands -> wreg_o = 1.
REQ-033 SRA, reg1 = 4, reg2 = 0xF0000000 -> wdata_o = 0xFF000000; SLTU with 0xFFFFFFFF vs 1 -> wdata_o = 0.
REQ-034 MULT, reg1 = 0xFFFFFFFF, reg2 = 2 -> whilo_o = 1, hi_o = 0xFFFFFFFF, lo_o = 0xFFFFFFFE.
REQ-035 MADD, hi/lo = 0/5, operands 3 and 4 -> cycle 1: stallreq_o = 1, whilo_o = 0; cycle 2: stallreq_o = 0, whilo_o = 1, lo_o = 17, hi_o = 0.
REQ-036 MSUB, hi/lo = 0/10, operands 2 and 3, hold_i = 1 for 3 cycles in ACC -> state held; after release, lo_o = 4 on the completing cycle.
REQ-037 rst asserted in ACC -> next cycle state = IDLE, stallreq_o = 0, whilo_o = 0, temp = 0.
